// File: rtl/vx_mchan_fifo_queue.sv
// Multi-channel FIFO: NUM_CH independent DEPTH-entry queues sharing one storage array,
// with per-channel flush and registered overflow/underflow error pulses.
module vx_mchan_fifo_queue #(
  parameter int NUM_CH    = 4,
  parameter int DATAW     = 32,
  parameter int DEPTH     = 8,
  parameter int ALM_FULL  = DEPTH - 1,
  parameter int ALM_EMPTY = 1,
  localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int SIZEW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic [CHW-1:0]          push_ch,
  input  logic [DATAW-1:0]        data_in,
  input  logic                    pop,
  input  logic [CHW-1:0]          pop_ch,
  output logic [DATAW-1:0]        data_out,
  input  logic [NUM_CH-1:0]       flush,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       alm_empty,
  output logic [NUM_CH-1:0]       alm_full,
  output logic [NUM_CH*SIZEW-1:0] size,
  output logic                    push_err,
  output logic                    pop_err
);

  localparam int PTRW = $clog2(DEPTH);

  logic [DATAW-1:0] mem    [NUM_CH*DEPTH];
  logic [PTRW-1:0]  wr_ptr [NUM_CH];
  logic [PTRW-1:0]  rd_ptr [NUM_CH];
  logic [SIZEW-1:0] size_q [NUM_CH];

  logic push_ok, pop_ok, push_drop, pop_drop;

  // A full channel still accepts a push when the same channel is popped this cycle.
  always_comb begin
    push_ok   = 1'b0;
    pop_ok    = 1'b0;
    push_drop = 1'b0;
    pop_drop  = 1'b0;
    if (push && !flush[push_ch]) begin
      push_ok   = !full[push_ch] || (pop && (pop_ch == push_ch));
      push_drop = !push_ok;
    end
    if (pop && !flush[pop_ch]) begin
      pop_ok   = !empty[pop_ch];
      pop_drop = empty[pop_ch];
    end
  end

  always_comb begin
    empty     = '0;
    full      = '0;
    alm_empty = '0;
    alm_full  = '0;
    size      = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      empty[c]               = (size_q[c] == '0);
      full[c]                = (size_q[c] == SIZEW'(DEPTH));
      alm_empty[c]           = (size_q[c] <= SIZEW'(ALM_EMPTY));
      alm_full[c]            = (size_q[c] >= SIZEW'(ALM_FULL));
      size[c*SIZEW +: SIZEW] = size_q[c];
    end
  end

  assign data_out = mem[{pop_ch, rd_ptr[pop_ch]}];

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[{push_ch, wr_ptr[push_ch]}] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        size_q[c] <= '0;
      end
      push_err <= 1'b0;
      pop_err  <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (flush[c]) begin
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
          size_q[c] <= '0;
        end else begin
          if (push_ok && (push_ch == CHW'(c)))
            wr_ptr[c] <= wr_ptr[c] + 1'b1;
          if (pop_ok && (pop_ch == CHW'(c)))
            rd_ptr[c] <= rd_ptr[c] + 1'b1;
          case ({push_ok && (push_ch == CHW'(c)), pop_ok && (pop_ch == CHW'(c))})
            2'b10:   size_q[c] <= size_q[c] + 1'b1;
            2'b01:   size_q[c] <= size_q[c] - 1'b1;
            default: size_q[c] <= size_q[c];
          endcase
        end
      end
      push_err <= push_drop;
      pop_err  <= pop_drop;
    end
  end

  a_push_ch_range : assert property (@(posedge clk) disable iff (!reset_n)
    push |-> (32'(push_ch) < NUM_CH));
  a_pop_ch_range : assert property (@(posedge clk) disable iff (!reset_n)
    pop |-> (32'(pop_ch) < NUM_CH));

endmodule

// File: tb/tb_vx_mchan_fifo_queue.sv
// Directed self-checking bench for vx_mchan_fifo_queue (NUM_CH=4, DATAW=32, DEPTH=8).
module tb_vx_mchan_fifo_queue;

  localparam int NUM_CH = 4;
  localparam int DATAW  = 32;
  localparam int DEPTH  = 8;
  localparam int CHW    = 2;
  localparam int SIZEW  = 4;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    push, pop;
  logic [CHW-1:0]          push_ch, pop_ch;
  logic [DATAW-1:0]        data_in, data_out;
  logic [NUM_CH-1:0]       flush, empty, full, alm_empty, alm_full;
  logic [NUM_CH*SIZEW-1:0] size;
  logic                    push_err, pop_err;

  int n_checks = 0;
  int n_fail   = 0;

  vx_mchan_fifo_queue #(
    .NUM_CH   (NUM_CH),
    .DATAW    (DATAW),
    .DEPTH    (DEPTH),
    .ALM_FULL (DEPTH - 1),
    .ALM_EMPTY(1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_ch  (push_ch),
    .data_in  (data_in),
    .pop      (pop),
    .pop_ch   (pop_ch),
    .data_out (data_out),
    .flush    (flush),
    .empty    (empty),
    .full     (full),
    .alm_empty(alm_empty),
    .alm_full (alm_full),
    .size     (size),
    .push_err (push_err),
    .pop_err  (pop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [SIZEW-1:0] sz(input int c);
    return size[c*SIZEW +: SIZEW];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input int ch, input logic [31:0] d);
    push    = 1'b1;
    push_ch = CHW'(ch);
    data_in = d;
    cyc();
    push = 1'b0;
  endtask

  task automatic do_pop(input string tag, input int ch, input logic [31:0] exp);
    pop_ch = CHW'(ch);
    #1;
    check(tag, data_out, exp);
    pop = 1'b1;
    cyc();
    pop = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_empty"},     32'(empty),     32'hF);
    check({tag, "_alm_empty"}, 32'(alm_empty), 32'hF);
    check({tag, "_full"},      32'(full),      32'h0);
    check({tag, "_alm_full"},  32'(alm_full),  32'h0);
    check({tag, "_size"},      32'(size),      32'h0);
    check({tag, "_push_err"},  32'(push_err),  32'h0);
    check({tag, "_pop_err"},   32'(pop_err),   32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    push = 1'b0; pop = 1'b0; push_ch = '0; pop_ch = '0; data_in = '0; flush = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst");
    reset_n = 1'b1;
    cyc();
    check_idle("idle");

    // Fill ch2 then drain it in order.
    for (int i = 0; i < 8; i++) begin
      do_push(2, 32'hA0 + 32'(i));
      check("t2_size", 32'(sz(2)), 32'(i + 1));
    end
    check("t2_full",     32'(full),     32'h4);
    check("t2_alm_full", 32'(alm_full), 32'h4);
    check("t2_size_vec", 32'(size),     32'h0800);
    for (int i = 0; i < 8; i++)
      do_pop("t2_data", 2, 32'hA0 + 32'(i));
    check("t2_end_empty", 32'(empty), 32'hF);
    check("t2_end_size",  32'(size),  32'h0);

    // Interleaved pushes across all channels, round-robin pops.
    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < 4; c++)
        do_push(c, 32'(16 * c + i));
      for (int c = 0; c < 4; c++)
        check("t3_push_size", 32'(sz(c)), 32'(i + 1));
      check("t3_alm_full",  32'(alm_full),  (i == 6) ? 32'hF : 32'h0);
      check("t3_alm_empty", 32'(alm_empty), (i == 0) ? 32'hF : 32'h0);
    end
    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < 4; c++)
        do_pop("t3_data", c, 32'(16 * c + i));
      for (int c = 0; c < 4; c++)
        check("t3_pop_size", 32'(sz(c)), 32'(6 - i));
    end
    check("t3_end_empty", 32'(empty), 32'hF);

    // Full ch1: simultaneous push and pop keeps size at DEPTH.
    for (int i = 0; i < 8; i++)
      do_push(1, 32'h40 + 32'(i));
    check("t4_full", 32'(full), 32'h2);
    pop_ch = 2'd1;
    #1;
    check("t4_head_before", data_out, 32'h40);
    push = 1'b1; push_ch = 2'd1; data_in = 32'h48; pop = 1'b1;
    cyc();
    push = 1'b0; pop = 1'b0;
    check("t4_size",     32'(sz(1)),   32'd8);
    check("t4_push_err", 32'(push_err), 32'h0);
    check("t4_head_after", data_out, 32'h41);
    for (int i = 0; i < 8; i++)
      do_pop("t4_data", 1, 32'h41 + 32'(i));
    check("t4_end_empty", 32'(empty), 32'hF);

    // Overflow on full ch3, underflow on empty ch0.
    for (int i = 0; i < 8; i++)
      do_push(3, 32'h30 + 32'(i));
    do_push(3, 32'h99);
    check("t5_push_err",  32'(push_err), 32'h1);
    check("t5_size3",     32'(sz(3)),    32'd8);
    cyc();
    check("t5_push_err_clr", 32'(push_err), 32'h0);
    pop = 1'b1; pop_ch = 2'd0;
    cyc();
    pop = 1'b0;
    check("t5_pop_err",  32'(pop_err), 32'h1);
    check("t5_size0",    32'(sz(0)),   32'd0);
    cyc();
    check("t5_pop_err_clr", 32'(pop_err), 32'h0);
    for (int i = 0; i < 8; i++)
      do_pop("t5_data", 3, 32'h30 + 32'(i));

    // Flush ch0 with a same-cycle push; ch1 stays intact.
    for (int i = 0; i < 5; i++) begin
      do_push(0, 32'h50 + 32'(i));
      do_push(1, 32'h60 + 32'(i));
    end
    check("t6_pre_size0", 32'(sz(0)), 32'd5);
    flush = 4'b0001; push = 1'b1; push_ch = 2'd0; data_in = 32'h77;
    cyc();
    flush = '0; push = 1'b0;
    check("t6_size0",     32'(sz(0)),    32'd0);
    check("t6_empty0",    32'(empty[0]), 32'h1);
    check("t6_push_err",  32'(push_err), 32'h0);
    check("t6_size1",     32'(sz(1)),    32'd5);

    // Pointer wrap on ch1 via paired push/pop.
    for (int i = 0; i < 20; i++) begin
      pop_ch = 2'd1;
      #1;
      check("t6_wrap_data", data_out, (i < 5) ? 32'h60 + 32'(i) : 32'h80 + 32'(i - 5));
      push = 1'b1; push_ch = 2'd1; data_in = 32'h80 + 32'(i); pop = 1'b1;
      cyc();
      push = 1'b0; pop = 1'b0;
      check("t6_wrap_size", 32'(sz(1)), 32'd5);
    end

    // Asynchronous reset while traffic is active.
    push = 1'b1; push_ch = 2'd2; data_in = 32'hEE; pop = 1'b1; pop_ch = 2'd1;
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_async_size",  32'(size),  32'h0);
    check("t6_async_empty", 32'(empty), 32'hF);
    check("t6_async_full",  32'(full),  32'h0);
    push = 1'b0; pop = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    check_idle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
